// File: rtl/gng_taus_urng_if.sv
// gng_taus_urng_if: seed/control inputs and sample outputs of the Tausworthe URNG
interface gng_taus_urng_if;
  logic ce;
  logic seed_load;
  logic [63:0] seed_z1;
  logic [63:0] seed_z2;
  logic [63:0] seed_z3;
  logic [2:0] seed_err;
  logic valid_out;
  logic [63:0] data_out;
  modport master(output ce, seed_load, seed_z1, seed_z2, seed_z3, input seed_err, valid_out, data_out);
  modport slave(input ce, seed_load, seed_z1, seed_z2, seed_z3, output seed_err, valid_out, data_out);
endinterface

// File: rtl/gng_taus_urng.sv
// gng_taus_urng: three-component 64-bit Tausworthe URNG with seed loading and warm-up discard
module gng_taus_urng #(
  parameter int WARMUP = 16,
  parameter logic [63:0] INIT_Z1 = 64'd5030521883283424767,
  parameter logic [63:0] INIT_Z2 = 64'd18445829279364155008,
  parameter logic [63:0] INIT_Z3 = 64'd18436106298727503359
) (
  input logic clk,
  input logic rst,
  gng_taus_urng_if.slave io
);
  typedef enum logic {WARM, RUN} state_t;
  localparam state_t START = (WARMUP == 0) ? RUN : WARM;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [63:0] z1, z2, z3, n1, n2, n3, b1, b2, b3;
  logic [2:0] bad;
  always_comb begin
    b1 = ((z1 << 5) ^ z1) >> 39;
    b2 = ((z2 << 19) ^ z2) >> 45;
    b3 = ((z3 << 24) ^ z3) >> 48;
    n1 = ((z1 & ~64'h1) << 24) ^ b1;
    n2 = ((z2 & ~64'h1FF) << 13) ^ b2;
    n3 = ((z3 & ~64'h7FF) << 7) ^ b3;
    bad = {io.seed_z3 < 64'd2048, io.seed_z2 < 64'd512, io.seed_z1 < 64'd2};
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    if (io.seed_load) begin
      state_d = START;
      cnt_d = '0;
    end else if (io.ce && state == WARM) begin
      cnt_d = cnt + 8'd1;
      state_d = (cnt == 8'(WARMUP - 1)) ? RUN : WARM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      z1 <= INIT_Z1;
      z2 <= INIT_Z2;
      z3 <= INIT_Z3;
      io.data_out <= '0;
      io.valid_out <= 1'b0;
      io.seed_err <= '0;
      cnt <= '0;
      state <= START;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      io.seed_err <= io.seed_load ? bad : 3'b000;
      if (io.seed_load) begin
        z1 <= bad[0] ? INIT_Z1 : io.seed_z1;
        z2 <= bad[1] ? INIT_Z2 : io.seed_z2;
        z3 <= bad[2] ? INIT_Z3 : io.seed_z3;
        io.valid_out <= 1'b0;
      end else if (io.ce) begin
        z1 <= n1;
        z2 <= n2;
        z3 <= n3;
        io.data_out <= n1 ^ n2 ^ n3;
        io.valid_out <= state == RUN;
      end else begin
        io.valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: doc/gng_taus_urng.md
Name: gng_taus_urng

Overview:
- Combined three-component 64-bit Tausworthe uniform random number generator with runtime seed loading and a warm-up discard phase.
- Sits directly upstream of the leading-zero/segment stage in the Gaussian noise generator.
- That stage consumes data_out[63:3] as its 61-bit magnitude field; the remaining bits feed sign and interpolation selection.
- One new 64-bit uniform sample per enabled cycle once running.

Parameters:
- WARMUP, 16: number of ce cycles discarded after reset or seed load before valid_out may assert; 0 means no discard. Range 0..255.
- INIT_Z1, 64'd5030521883283424767: default/replacement seed for component 1.
- INIT_Z2, 64'd18445829279364155008: default/replacement seed for component 2.
- INIT_Z3, 64'd18436106298727503359: default/replacement seed for component 3.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  advance generator one step
- seed_load  in  1  single-cycle strobe: load seed_z1..seed_z3
- seed_z1  in  64  component-1 seed
- seed_z2  in  64  component-2 seed
- seed_z3  in  64  component-3 seed
- seed_err  out  3  registered one-cycle flags; bit i set = seed_z(i+1) was illegal and was replaced
- valid_out  out  1  data_out holds a valid sample this cycle
- data_out  out  64  uniform sample

Behaviour:
- Reset (rst=1 at an edge):
  - z1/z2/z3 <= INIT_Z1/INIT_Z2/INIT_Z3.
  - data_out <= 0; valid_out <= 0; seed_err <= 0.
  - Warm-up counter <= 0; FSM <= WARMUP, or RUN if WARMUP==0.
  - rst overrides seed_load and ce in the same cycle.
- Step function, all shifts logical, 64-bit:
  - b1 = ((z1<<5)^z1)>>39;  z1' = ((z1 & ~64'h1)<<24) ^ b1
  - b2 = ((z2<<19)^z2)>>45; z2' = ((z2 & ~64'h1FF)<<13) ^ b2
  - b3 = ((z3<<24)^z3)>>48; z3' = ((z3 & ~64'h7FF)<<7) ^ b3
- Priority at each edge: rst > seed_load > ce > hold.
- Seed load (seed_load=1, rst=0):
  - Legality: seed_z1 >= 2, seed_z2 >= 512, seed_z3 >= 2048, unsigned.
  - Each illegal seed is replaced by its INIT_Zn value; the matching seed_err bit is set for exactly the next cycle.
  - Warm-up counter cleared; FSM -> WARMUP, or RUN if WARMUP==0.
  - valid_out <= 0; data_out holds.
  - A simultaneous ce is ignored; no step occurs.
- ce=1, no load:
  - State advances to z'.
  - data_out <= z1'^z2'^z3', registered, so latency is 1 cycle from the ce edge.
  - Data updates in WARMUP and RUN alike.
- FSM:
  - WARMUP: each ce increments the counter. On the ce where counter==WARMUP-1, go to RUN. valid_out <= 0 throughout.
  - RUN: valid_out <= ce.
- ce=0: state, data_out and counter hold; valid_out <= 0.
- seed_err <= 0 on every cycle without a seed_load.
- No backpressure: the consumer must accept every valid_out cycle. Stall the source with ce.

Test Plan:
- rst 1 cycle, then ce=1 continuously, WARMUP=16 -> valid_out low through the 17th ce edge. The first valid_out=1 appears the cycle after that edge, and data_out equals the 17th step of the C golden model from INIT seeds. Subsequent samples match the model every cycle.
- ce pattern 1,0,0,1 in RUN -> data_out and z hold across the ce=0 cycles; valid_out = 1,0,0,1 delayed by one cycle; the sample sequence is identical to continuous ce.
- seed_load with seed_z1=0, seed_z2=100, seed_z3=5000 -> seed_err=3'b011 for one cycle. State = {INIT_Z1, INIT_Z2, 5000}; the output sequence after warm-up matches the golden model from those seeds.
- seed_load and ce both high in RUN, legal seeds {2, 512, 2048} -> no step taken; valid_out=0 next cycle; seed_err=0. 16 ce edges of warm-up precede the next valid, and the first valid sample equals model step 17 from {2, 512, 2048}.
- rst for 1 cycle mid-RUN with ce=1 -> data_out=0 and valid_out=0 the next cycle; the sequence thereafter is bit-identical to scenario 1.
- WARMUP=0 build, rst then ce=1 -> valid_out=1 on the cycle after the first ce edge; data_out = model step 1.
